// File: rtl/lopd_pkg.sv
// rtl/lopd_pkg.sv - shared constants, width helper and stage record for the leading-one detector pipe
package lopd_pkg;

    localparam int LOPD_DEF_SIZE_DATA = 24;
    localparam int LOPD_DEF_SIZE_TAG  = 4;

    // Stage records are sized for the widest supported configuration; each
    // instance uses only the low bits of every field.
    localparam int LOPD_MAX_DATA = 64;
    localparam int LOPD_MAX_POS  = 6;
    localparam int LOPD_MAX_TAG  = 16;

    function automatic int f_lopd_width(input int n);
        return $clog2(n);
    endfunction

    typedef struct packed {
        logic [LOPD_MAX_DATA-1:0] data;
        logic [LOPD_MAX_POS-1:0]  pos;
        logic                     zero;
        logic [LOPD_MAX_TAG-1:0]  tag;
    } lopd_stage_t;

endpackage

// File: rtl/lopd_tree.sv
// rtl/lopd_tree.sv - combinational recursive leading-one detector producing {pos, zero}
module lopd_tree #(
    parameter int N = 24,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] data,
    output logic [W-1:0] pos,
    output logic         zero
);

    generate
        if (N == 1) begin : g_leaf
            assign pos  = '0;
            assign zero = ~data[0];
        end else if (N == 2) begin : g_pair
            assign pos  = data[1];
            assign zero = ~|data;
        end else begin : g_split
            // Low half is the largest power of two below N, so the high half
            // starts on an aligned boundary and its index is just an MSB prefix.
            localparam int H  = 1 << (W - 1);
            localparam int NU = N - H;
            localparam int WU = (NU > 1) ? $clog2(NU) : 1;

            logic [W-2:0]  lo_pos;
            logic          lo_zero;
            logic [WU-1:0] up_pos;
            logic          up_zero;

            lopd_tree #(.N(H), .W(W - 1)) u_lo (
                .data (data[H-1:0]),
                .pos  (lo_pos),
                .zero (lo_zero)
            );

            lopd_tree #(.N(NU), .W(WU)) u_hi (
                .data (data[N-1:H]),
                .pos  (up_pos),
                .zero (up_zero)
            );

            assign pos  = up_zero ? {1'b0, lo_pos} : {1'b1, (W - 1)'(up_pos)};
            assign zero = lo_zero & up_zero;
        end
    endgenerate

endmodule

// File: rtl/lopd_norm_pipe.sv
// rtl/lopd_norm_pipe.sv - two-stage leading-one detector/normaliser pipe; LOPD_NORM_SHIFT_EN adds the barrel shifter
module lopd_norm_pipe
    import lopd_pkg::*;
#(
    parameter int SIZE_DATA = LOPD_DEF_SIZE_DATA,
    parameter int SIZE_LOPD = f_lopd_width(SIZE_DATA),
    parameter int SIZE_TAG  = LOPD_DEF_SIZE_TAG
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [SIZE_DATA-1:0] i_data,
    input  logic [SIZE_TAG-1:0]  i_tag,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [SIZE_LOPD-1:0] o_one_position,
    output logic [SIZE_LOPD-1:0] o_shift_amt,
    output logic                 o_zero_flag,
    output logic [SIZE_DATA-1:0] o_norm_data,
    output logic [SIZE_TAG-1:0]  o_tag
);

    logic                 s1_valid;
    logic                 s2_valid;
    logic                 s1_en;
    logic                 s2_en;
    lopd_stage_t          s1;
    lopd_stage_t          s2;
    logic [SIZE_LOPD-1:0] s2_shift;
    logic [SIZE_LOPD-1:0] tree_pos;
    logic                 tree_zero;
    logic [SIZE_LOPD-1:0] s1_shift;
    logic                 unused_stage_bits;

    lopd_tree #(.N(SIZE_DATA), .W(SIZE_LOPD)) u_tree (
        .data (i_data),
        .pos  (tree_pos),
        .zero (tree_zero)
    );

    assign s2_en   = ~s2_valid | i_ready;
    assign s1_en   = ~s1_valid | s2_en;
    assign o_ready = s1_en;

    // A zero operand reports shift 0 rather than SIZE_DATA-1.
    assign s1_shift = s1.zero ? '0 : SIZE_LOPD'(SIZE_DATA - 1) - s1.pos[SIZE_LOPD-1:0];

`ifdef LOPD_NORM_SHIFT_EN
    logic [SIZE_DATA-1:0] s1_norm;
    assign s1_norm = s1.data[SIZE_DATA-1:0] << s1_shift;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1       <= '0;
            s2       <= '0;
            s2_shift <= '0;
        end else begin
            if (s1_en) s1_valid <= i_valid;
            if (s2_en) s2_valid <= s1_valid;

            if (s1_en && i_valid) begin
`ifdef LOPD_NORM_SHIFT_EN
                s1.data <= LOPD_MAX_DATA'(i_data);
`endif
                s1.pos  <= LOPD_MAX_POS'(tree_pos);
                s1.zero <= tree_zero;
                s1.tag  <= LOPD_MAX_TAG'(i_tag);
            end

            if (s2_en && s1_valid) begin
`ifdef LOPD_NORM_SHIFT_EN
                s2.data <= LOPD_MAX_DATA'(s1_norm);
`endif
                s2.pos   <= s1.pos;
                s2.zero  <= s1.zero;
                s2.tag   <= s1.tag;
                s2_shift <= s1_shift;
            end
        end
    end

    assign o_valid        = s2_valid;
    assign o_one_position = s2.pos[SIZE_LOPD-1:0];
    assign o_shift_amt    = s2_shift;
    assign o_zero_flag    = s2.zero;
    assign o_tag          = s2.tag[SIZE_TAG-1:0];

`ifdef LOPD_NORM_SHIFT_EN
    assign o_norm_data = s2.data[SIZE_DATA-1:0];
`else
    assign o_norm_data = '0;
`endif

    assign unused_stage_bits = ^{s1, s2};

endmodule

// File: tb/tb_lopd_norm_pipe.sv
// tb/tb_lopd_norm_pipe.sv - self-checking bench for lopd_norm_pipe (24-bit and 53-bit instances)
module tb_lopd_norm_pipe;

`ifdef LOPD_NORM_SHIFT_EN
    localparam bit NORM_EN = 1'b1;
`else
    localparam bit NORM_EN = 1'b0;
`endif

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [23:0] i_data;
    logic [3:0]  i_tag;
    logic        o_valid;
    logic        i_ready;
    logic [4:0]  o_one_position;
    logic [4:0]  o_shift_amt;
    logic        o_zero_flag;
    logic [23:0] o_norm_data;
    logic [3:0]  o_tag;

    logic        b_valid;
    logic        b_oready;
    logic [52:0] b_data;
    logic [3:0]  b_tag;
    logic        b_ovalid;
    logic        b_ready;
    logic [5:0]  b_pos;
    logic [5:0]  b_shift;
    logic        b_zero;
    logic [52:0] b_norm;
    logic [3:0]  b_otag;

    int checks = 0;
    int errors = 0;

    lopd_norm_pipe dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_data         (i_data),
        .i_tag          (i_tag),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_one_position (o_one_position),
        .o_shift_amt    (o_shift_amt),
        .o_zero_flag    (o_zero_flag),
        .o_norm_data    (o_norm_data),
        .o_tag          (o_tag)
    );

    lopd_norm_pipe #(.SIZE_DATA(53), .SIZE_TAG(4)) dut_big (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_valid        (b_valid),
        .o_ready        (b_oready),
        .i_data         (b_data),
        .i_tag          (b_tag),
        .o_valid        (b_ovalid),
        .i_ready        (b_ready),
        .o_one_position (b_pos),
        .o_shift_amt    (b_shift),
        .o_zero_flag    (b_zero),
        .o_norm_data    (b_norm),
        .o_tag          (b_otag)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    typedef struct packed {
        logic [5:0]  pos;
        logic [5:0]  shift;
        logic        zero;
        logic [63:0] norm;
    } exp_t;

    typedef struct {
        logic [23:0] data;
        logic [3:0]  tag;
        int          pos;
        int          shift;
        bit          zero;
        logic [23:0] norm;
    } vec_t;

    typedef struct packed {
        logic [23:0] data;
        logic [3:0]  tag;
    } op_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: scan for the highest set bit, then multiply up to the top.
    function automatic exp_t model(input logic [63:0] d, input int n);
        exp_t        e;
        int          top;
        logic [63:0] mask;
        top = -1;
        for (int i = 0; i < n; i++) if (d[i]) top = i;
        mask   = (n == 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
        e.zero = (top < 0);
        e.pos  = e.zero ? 6'd0 : 6'(top);
        e.shift = e.zero ? 6'd0 : 6'(n - 1 - top);
        e.norm = (NORM_EN && !e.zero) ? ((d * (64'd1 << (n - 1 - top))) & mask) : 64'd0;
        return e;
    endfunction

    task automatic send_and_wait(input logic [23:0] d, input logic [3:0] t, output bit got);
        i_data  = d;
        i_tag   = t;
        i_valid = 1'b1;
        i_ready = 1'b1;
        got     = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge i_clk);
            if (o_ready) break;
        end
        @(posedge i_clk);
        #1 i_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge i_clk);
            if (o_valid) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        vec_t        vecs[5];
        op_t         q[$];
        exp_t        e;
        bit          got;
        logic [31:0] r;
        logic [63:0] bd;
        int          n_out;

        vecs[0] = '{24'h800000, 4'h1, 23, 0,  1'b0, 24'h800000};
        vecs[1] = '{24'h000001, 4'h2, 0,  23, 1'b0, 24'h800000};
        vecs[2] = '{24'h00F0A3, 4'h3, 15, 8,  1'b0, 24'hF0A300};
        vecs[3] = '{24'h000000, 4'h5, 0,  0,  1'b1, 24'h000000};
        vecs[4] = '{24'h7FFFFF, 4'hA, 22, 1,  1'b0, 24'hFFFFFE};

        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_data  = '0;
        i_tag   = '0;
        i_ready = 1'b0;
        b_valid = 1'b0;
        b_data  = '0;
        b_tag   = '0;
        b_ready = 1'b0;

        #2;
        check("rst_o_valid", 64'(o_valid), 64'd0);
        check("rst_o_ready", 64'(o_ready), 64'd1);
        check("rst_outputs", {o_one_position, o_shift_amt, o_zero_flag, o_norm_data, o_tag}, 64'd0);
        @(posedge i_clk);
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        check("post_rst_o_ready", 64'(o_ready), 64'd1);

        for (int i = 0; i < 5; i++) begin
            send_and_wait(vecs[i].data, vecs[i].tag, got);
            check($sformatf("vec%0d_arrive", i), 64'(got), 64'd1);
            check($sformatf("vec%0d_pos", i), 64'(o_one_position), 64'(vecs[i].pos));
            check($sformatf("vec%0d_shift", i), 64'(o_shift_amt), 64'(vecs[i].shift));
            check($sformatf("vec%0d_zero", i), 64'(o_zero_flag), 64'(vecs[i].zero));
            check($sformatf("vec%0d_norm", i), 64'(o_norm_data), NORM_EN ? 64'(vecs[i].norm) : 64'd0);
            check($sformatf("vec%0d_tag", i), 64'(o_tag), 64'(vecs[i].tag));
            @(posedge i_clk);
            #1;
        end

        // Two-cycle latency from an empty pipe.
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = 24'h004000;
        i_tag   = 4'h7;
        @(negedge i_clk);
        check("lat_ready", 64'(o_ready), 64'd1);
        @(posedge i_clk);
        #1 i_valid = 1'b0;
        check("lat_k_valid", 64'(o_valid), 64'd0);
        @(posedge i_clk);
        #1;
        check("lat_k1_valid", 64'(o_valid), 64'd1);
        check("lat_k1_pos", {o_tag, o_one_position}, {4'h7, 5'd14});
        @(posedge i_clk);
        #1;
        check("lat_drained", 64'(o_valid), 64'd0);

        // Stall: three back-to-back operands while downstream is blocked.
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 24'h000100;
        i_tag   = 4'h1;
        @(negedge i_clk);
        check("stall_ready0", 64'(o_ready), 64'd1);
        @(posedge i_clk);
        #1 i_data = 24'h010000;
        i_tag = 4'h2;
        @(negedge i_clk);
        check("stall_ready1", 64'(o_ready), 64'd1);
        @(posedge i_clk);
        #1 i_data = 24'h000003;
        i_tag = 4'h3;
        for (int c = 0; c < 4; c++) begin
            @(negedge i_clk);
            check($sformatf("stall_full_ready%0d", c), 64'(o_ready), 64'd0);
            check($sformatf("stall_hold%0d", c), {o_valid, o_tag, o_one_position, o_shift_amt},
                  {1'b1, 4'h1, 5'd8, 5'd15});
            @(posedge i_clk);
            #1;
        end
        i_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge i_clk);
            e = model((k == 1) ? 64'h100 : (k == 2) ? 64'h10000 : 64'h3, 24);
            check($sformatf("stall_out%0d", k), {o_valid, o_tag, o_one_position},
                  {1'b1, 4'(k), e.pos[4:0]});
            @(posedge i_clk);
            #1 if (k == 1) i_valid = 1'b0;
        end
        @(negedge i_clk);
        check("stall_no_dup", 64'(o_valid), 64'd0);

        // Reset with two operands in flight.
        @(posedge i_clk);
        #1 i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 24'h000800;
        i_tag   = 4'h9;
        @(posedge i_clk);
        #1 i_tag = 4'hA;
        @(posedge i_clk);
        #1 i_valid = 1'b0;
        check("flush_pre_valid", 64'(o_valid), 64'd1);
        i_rst = 1'b1;
        #1;
        check("flush_o_valid", 64'(o_valid), 64'd0);
        check("flush_o_ready", 64'(o_ready), 64'd1);
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        i_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge i_clk);
            check($sformatf("flush_quiet%0d", c), 64'(o_valid), 64'd0);
        end
        @(posedge i_clk);
        #1 i_valid = 1'b1;
        i_data = 24'h000020;
        i_tag  = 4'hC;
        @(posedge i_clk);
        #1 i_valid = 1'b0;
        check("flush_lat_k", 64'(o_valid), 64'd0);
        @(posedge i_clk);
        #1;
        check("flush_lat_k1", {o_valid, o_tag, o_one_position, o_shift_amt}, {1'b1, 4'hC, 5'd5, 5'd18});
        @(posedge i_clk);
        #1;

        // 53-bit instance: top bit set, then random operands.
        b_ready = 1'b1;
        for (int v = 0; v < 16; v++) begin
            if (v == 0) bd = 64'd1 << 52;
            else bd = ({$urandom, $urandom} & ((64'd1 << 53) - 64'd1)) >> $urandom_range(0, 53);
            b_data  = bd[52:0];
            b_tag   = 4'(v);
            b_valid = 1'b1;
            @(negedge i_clk);
            check($sformatf("big%0d_ready", v), 64'(b_oready), 64'd1);
            @(posedge i_clk);
            #1 b_valid = 1'b0;
            @(posedge i_clk);
            #1;
            e = model(bd, 53);
            check($sformatf("big%0d_ctl", v), {b_ovalid, b_otag, b_pos, b_shift, b_zero},
                  {1'b1, 4'(v), e.pos, e.shift, e.zero});
            check($sformatf("big%0d_norm", v), 64'(b_norm), e.norm);
            @(posedge i_clk);
            #1;
        end

        // Random traffic against a queue scoreboard.
        for (int c = 0; c < 600; c++) begin
            r       = $urandom;
            i_valid = ($urandom_range(0, 3) != 0);
            i_data  = r[23:0] >> $urandom_range(0, 24);
            i_tag   = 4'($urandom);
            i_ready = ($urandom_range(0, 3) != 0);
            @(negedge i_clk);
            if (o_valid) begin
                if (q.size() == 0) begin
                    check("rnd_spurious", 64'(o_valid), 64'd0);
                end else begin
                    e = model(64'(q[0].data), 24);
                    check("rnd_out", {o_tag, o_one_position, o_shift_amt, o_zero_flag, o_norm_data},
                          {q[0].tag, e.pos[4:0], e.shift[4:0], e.zero, e.norm[23:0]});
                    if (i_ready) void'(q.pop_front());
                end
            end
            if (i_valid && o_ready) q.push_back('{i_data, i_tag});
            @(posedge i_clk);
            #1;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        n_out = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge i_clk);
            if (o_valid && q.size() != 0) begin
                e = model(64'(q[0].data), 24);
                check("rnd_drain_out", {o_tag, o_one_position, o_shift_amt, o_zero_flag, o_norm_data},
                      {q[0].tag, e.pos[4:0], e.shift[4:0], e.zero, e.norm[23:0]});
                void'(q.pop_front());
                n_out++;
            end else if (o_valid) begin
                check("rnd_drain_spurious", 64'(o_valid), 64'd0);
            end
        end
        check("rnd_drain_empty", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
